inst_encode_loader: RTL and testbench
=====================================

Name: inst_encode_loader

Overview:
- Inverse of the instruction decode stage: takes decoded instruction fields (format, opcode, funct, register indices, shamt, immediate, jump address) and packs them into 32-bit MIPS instruction words.
- Streams the packed words, each with its sequential instruction-memory address, into the instruction memory write port.
- Used by the testbench/boot path to load programs into instruction memory.
- Buffered by a small FIFO with valid/ready handshakes on both sides.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, at least 2).
- BASE_ADDR, 32'h0040_0000, address of first emitted word.
- ADDR_STEP, 4, byte increment per emitted word.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a new program load.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept the bundle.
- in_fmt  in  2  0=R, 1=I, 2=J, 3=illegal.
- in_op  in  6  opcode (I/J formats).
- in_funct  in  6  funct (R format).
- in_rs, in_rt, in_rd  in  5 each  register indices.
- in_sha  in  5  shift amount.
- in_imm  in  16  immediate.
- in_addr  in  26  jump address field.
- in_last  in  1  bundle is final instruction of the program.
- out_valid  out  1  out_inst/out_addr valid.
- out_ready  in  1  memory accepts the write this cycle.
- out_addr  out  32  byte address for out_inst.
- out_inst  out  32  encoded instruction word.
- count  out  16  words written (popped) since start.
- done  out  1  load complete.
- err  out  1  sticky: illegal format seen since start.

Behaviour:
Reset:
- state=IDLE, FIFO empty, write address=BASE_ADDR.
- in_ready=0, out_valid=0, out_addr=0, out_inst=0, count=0, done=0, err=0.

Encoding, registered into the FIFO on an accepted bundle:
- R: {6'b0, rs, rt, rd, sha, funct}; in_op is ignored.
- I: {op, rs, rt, imm}.
- J: {op, addr}.
- fmt=3: bundle is consumed (handshake completes), no FIFO entry is made, no address is consumed, err is set. If in_last=1, the end-of-program transition still occurs.

Addressing:
- Each FIFO entry carries its address.
- The write-address counter starts at BASE_ADDR on start and advances by ADDR_STEP on each push.
- The counter wraps modulo 2^32.

Handshakes:
- Input transfer occurs when in_valid && in_ready.
- in_ready = (state==LOAD) && !full. It is not combinationally dependent on out_ready, so there is no pass-through when full.
- Output transfer (pop) occurs when out_valid && out_ready.
- out_valid = !empty; out_inst/out_addr come from the FIFO head.
- While out_valid=1 and out_ready=0, out_inst and out_addr hold stable.
- Latency from accept to out_valid is 1 cycle when the FIFO was empty.
- Push and pop in the same cycle are allowed; occupancy is unchanged.

Counters:
- count increments on each pop and saturates at 16'hFFFF.

State machine:
- IDLE: in_ready=0. start -> LOAD.
- LOAD: accept bundles. Accepted bundle with in_last=1 -> DRAIN.
- DRAIN: in_ready=0; keep emitting. FIFO empty -> DONE.
- DONE: done=1, held until the next start or rst.

start (any state):
- Next cycle: FIFO flushed, write address=BASE_ADDR, count=0, err=0, done=0, state=LOAD.
- start takes priority over a simultaneous input or output transfer. That transfer is discarded; the upstream must not treat it as delivered.

Reset mid-load: discards all entries, returns to IDLE.

Test Plan:
- R-type: start; bundle fmt=0, rs=1, rt=2, rd=3, sha=0, funct=6'h20, last=1 -> out_inst=32'h00221820, out_addr=32'h00400000, one cycle after accept; count=1; done=1 after pop.
- I and J sequence: fmt=1, op=6'h08, rs=0, rt=8, imm=16'hFFFF, then fmt=2, op=6'h02, addr=26'h0100000, last=1 -> 32'h2008FFFF @0x00400000, then 32'h08100000 @0x00400004.
- Back-pressure: out_ready=0, push 5 bundles with DEPTH=4 -> in_ready drops after 4 accepts; out_inst stable. Release out_ready -> all 5 emitted in order with consecutive addresses; count=5.
- Illegal format: middle bundle fmt=3 among three -> err=1, only 2 words written, at 0x00400000 and 0x00400004.
- Restart: assert start while 2 entries are queued -> out_valid=0 next cycle, count=0, next word at BASE_ADDR.
- Reset: assert rst during DRAIN -> all outputs at reset values next cycle; in_ready=0 until start.

Source files
------------

// File: rtl/inst_encode_loader.sv
// inst_encode_loader
//   Packs decoded MIPS instruction fields back into 32-bit instruction words
//   and streams them, each tagged with its sequential byte address, into an
//   instruction-memory write port.  A DEPTH-entry FIFO sits between the
//   field-bundle input and the memory-write output.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge
//   where valid && ready are both 1.  in_ready never looks at out_ready and
//   out_valid never looks at in_valid, so no combinational path crosses
//   the FIFO.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse: flush and begin a new program load
//   in_valid/in_ready   field bundle handshake
//   in_fmt              0=R, 1=I, 2=J, 3=illegal (consumed, sets err)
//   in_op .. in_addr    decoded instruction fields
//   in_last             bundle is the last instruction of the program
//   out_valid/out_ready memory write handshake
//   out_addr, out_inst  byte address and encoded word (FIFO head, 0 if empty)
//   count               words popped since start (saturating)
//   done                load complete, held until start or rst
//   err                 sticky: illegal format seen since start
//   dbg_state           current FSM state (0 IDLE, 1 LOAD, 2 DRAIN, 3 DONE)
module inst_encode_loader #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [5:0]  in_op,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_sha,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_addr,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_inst,
  output logic [15:0] count,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [63:0]  r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [31:0]  r_wr_addr;
  logic [15:0]  r_count;
  logic         r_err;

  logic         w_empty;
  logic         w_full;
  logic         w_in_fire;
  logic         w_push;
  logic         w_pop;
  logic [31:0]  w_inst;
  logic [63:0]  w_head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign in_ready  = (r_state == S_LOAD) && !w_full;
  assign out_valid = !w_empty;
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign out_inst  = w_empty ? 32'd0 : w_head[31:0];
  assign out_addr  = w_empty ? 32'd0 : w_head[63:32];
  assign count     = r_count;
  assign err       = r_err;
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

  // start wins over any same-cycle transfer: that transfer is dropped.
  assign w_in_fire = in_valid && in_ready && !start;
  assign w_push    = w_in_fire && (in_fmt != 2'd3);
  assign w_pop     = out_valid && out_ready && !start;

  always_comb begin
    w_inst = 32'd0;
    case (in_fmt)
      2'd0:    w_inst = {6'b0, in_rs, in_rt, in_rd, in_sha, in_funct};
      2'd1:    w_inst = {in_op, in_rs, in_rt, in_imm};
      2'd2:    w_inst = {in_op, in_addr};
      default: w_inst = 32'd0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_IDLE;
      S_LOAD:  if (w_in_fire && in_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_empty) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (start) w_state_nxt = S_LOAD;
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {r_wr_addr, w_inst};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_wr_addr <= BASE_ADDR;
      r_count   <= 16'd0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (start) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_wr_addr <= BASE_ADDR;
        r_count   <= 16'd0;
        r_err     <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr  <= r_wr_ptr + 1'b1;
          r_wr_addr <= r_wr_addr + ADDR_STEP;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
        end
        // Illegal bundles are consumed without using an entry or address.
        if (w_in_fire && (in_fmt == 2'd3)) r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encode_loader.sv
module tb_inst_encode_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_DONE = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, in_last, out_ready;
  logic [1:0]  in_fmt;
  logic [5:0]  in_op, in_funct;
  logic [4:0]  in_rs, in_rt, in_rd, in_sha;
  logic [15:0] in_imm;
  logic [25:0] in_addr;
  logic        in_ready, out_valid, done, err;
  logic [31:0] out_addr, out_inst;
  logic [15:0] count;
  logic [1:0]  dbg_state;

  inst_encode_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .ADDR_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_op(in_op), .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_sha(in_sha), .in_imm(in_imm), .in_addr(in_addr),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_inst(out_inst), .count(count),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [63:0] exp_q[$];    // {addr, inst} words expected at the output
  logic [63:0] got_log[$];  // words actually popped from the DUT
  int          m_phase;
  logic [31:0] m_addr;
  int          m_count;
  bit          m_err;
  bit          in_acc;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] encode(input logic [1:0] f, input logic [5:0] op, input logic [5:0] fn,
                                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] a);
    logic [31:0] e;
    e = 32'd0;
    if (f == 2'd0)
      e = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
    else if (f == 2'd1)
      e = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    else if (f == 2'd2)
      e = (32'(op) << 26) | 32'(a);
    return e;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_addr  = BASE;
    m_count = 0;
    m_err   = 1'b0;
  endtask

  task automatic check_outputs();
    check_val("out_valid", out_valid, exp_q.size() != 0);
    check_val("in_ready", in_ready, (m_phase == P_LOAD) && (exp_q.size() < DEPTH));
    if (exp_q.size() != 0) begin
      check_val("out_inst", out_inst, exp_q[0][31:0]);
      check_val("out_addr", out_addr, exp_q[0][63:32]);
    end else begin
      check_val("out_inst_idle", out_inst, 32'd0);
      check_val("out_addr_idle", out_addr, 32'd0);
    end
    check_val("count", count, m_count);
    check_val("done", done, m_phase == P_DONE);
    check_val("err", err, m_err);
  endtask

  // Called at a negedge with inputs set: predicts the coming edge, then checks.
  task automatic clk_cycle();
    bit ir, ov;
    ir = (m_phase == P_LOAD) && (exp_q.size() < DEPTH);
    ov = (exp_q.size() != 0);
    in_acc = 1'b0;
    if (rst) begin
      model_clear();
      m_phase = P_IDLE;
    end else if (start) begin
      model_clear();
      m_phase = P_LOAD;
    end else begin
      if (m_phase == P_DRAIN && !ov) m_phase = P_DONE;
      if (ov && out_ready) begin
        got_log.push_back({out_addr, out_inst});
        void'(exp_q.pop_front());
        if (m_count < 65535) m_count++;
      end
      if (ir && in_valid) begin
        in_acc = 1'b1;
        if (in_fmt != 2'd3) begin
          exp_q.push_back({m_addr, encode(in_fmt, in_op, in_funct, in_rs, in_rt, in_rd,
                                          in_sha, in_imm, in_addr)});
          m_addr = m_addr + 32'd4;
        end else begin
          m_err = 1'b1;
        end
        if (in_last) m_phase = P_DRAIN;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_fields(input logic [1:0] f, input logic [5:0] op, input logic [5:0] fn,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] a,
                            input logic l);
    in_fmt = f; in_op = op; in_funct = fn; in_rs = rs; in_rt = rt; in_rd = rd;
    in_sha = sh; in_imm = imm; in_addr = a; in_last = l;
  endtask

  task automatic set_random_fields(input logic [1:0] f, input logic l);
    set_fields(f, 6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 16'($urandom), 26'($urandom), l);
  endtask

  task automatic wait_accept(input string tag);
    in_valid = 1'b1;
    in_acc = 1'b0;
    for (int k = 0; k < 50 && !in_acc; k++) clk_cycle();
    if (!in_acc) check_val({tag, "_accept_timeout"}, 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    clk_cycle();
    start = 1'b0;
    got_log.delete();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) clk_cycle();
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] held;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(2'd0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
    model_clear();
    m_phase = P_IDLE;
    @(negedge clk);
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(2);

    // R-type single instruction
    do_start();
    set_fields(2'd0, 6'h3F, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1);
    wait_accept("r");
    check_val("r_inst", out_inst, 32'h0022_1820);
    check_val("r_addr", out_addr, 32'h0040_0000);
    idle_cycles(3);
    check_val("r_count", count, 16'd1);
    check_val("r_done", done, 1'b1);

    // I then J
    do_start();
    set_fields(2'd1, 6'h08, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1'b0);
    wait_accept("i");
    set_fields(2'd2, 6'h02, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0100000, 1'b1);
    wait_accept("j");
    idle_cycles(4);
    check_val("ij_words", got_log.size(), 2);
    if (got_log.size() == 2) begin
      check_val("ij_w0", got_log[0], {32'h0040_0000, 32'h2008_FFFF});
      check_val("ij_w1", got_log[1], {32'h0040_0004, 32'h0810_0000});
    end

    // Back-pressure: five bundles into a four-entry FIFO
    do_start();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_random_fields(2'($urandom_range(0, 2)), 1'b0);
      wait_accept("bp");
    end
    check_val("bp_full_ready", in_ready, 1'b0);
    held = out_inst;
    set_random_fields(2'($urandom_range(0, 2)), 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_cycle();
      check_val("bp_stall", in_acc, 1'b0);
      check_val("bp_hold", out_inst, held);
    end
    out_ready = 1'b1;
    wait_accept("bp5");
    idle_cycles(8);
    check_val("bp_words", got_log.size(), 5);
    for (int i = 0; i < got_log.size(); i++)
      check_val("bp_addr", got_log[i][63:32], BASE + 32'(4 * i));
    check_val("bp_count", count, 16'd5);

    // Illegal format in the middle
    do_start();
    set_random_fields(2'd1, 1'b0); wait_accept("il0");
    set_random_fields(2'd3, 1'b0); wait_accept("il1");
    set_random_fields(2'd2, 1'b1); wait_accept("il2");
    idle_cycles(4);
    check_val("il_err", err, 1'b1);
    check_val("il_words", got_log.size(), 2);
    if (got_log.size() == 2) begin
      check_val("il_a0", got_log[0][63:32], 32'h0040_0000);
      check_val("il_a1", got_log[1][63:32], 32'h0040_0004);
    end

    // Restart with entries queued
    do_start();
    out_ready = 1'b0;
    set_random_fields(2'd0, 1'b0); wait_accept("rs0");
    set_random_fields(2'd1, 1'b0); wait_accept("rs1");
    do_start();
    check_val("rs_valid", out_valid, 1'b0);
    check_val("rs_count", count, 16'd0);
    out_ready = 1'b1;
    set_random_fields(2'd2, 1'b1); wait_accept("rs2");
    idle_cycles(3);
    check_val("rs_words", got_log.size(), 1);
    if (got_log.size() == 1) check_val("rs_addr", got_log[0][63:32], BASE);

    // Reset during DRAIN
    do_start();
    out_ready = 1'b0;
    set_random_fields(2'd0, 1'b0); wait_accept("rd0");
    set_random_fields(2'd1, 1'b1); wait_accept("rd1");
    check_val("rd_in_drain", dbg_state, 2'd2);
    rst = 1'b1;
    clk_cycle();
    rst = 1'b0;
    check_val("rd_valid", out_valid, 1'b0);
    check_val("rd_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    idle_cycles(3);
    in_valid = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      start     = ((m_phase == P_IDLE || m_phase == P_DONE) && $urandom_range(0, 3) == 0) ||
                  ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_random_fields(($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                        $urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 499) == 0);
      clk_cycle();
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
